vx_dispatch_arb: RTL and testbench

VX_DISPATCH_ARB -- requirements
Module: VX_dispatch_arb

---
 rtl/vx_dispatch_arb.sv | 91 +++++++++
 tb/tb_vx_dispatch_arb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vx_dispatch_arb.sv
// Round-robin dispatch arbiter: NUM_REQS lanes share one registered output slice
// toward an execution unit, with per-lane saturating stall counters.
module vx_dispatch_arb #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 32,
  parameter int CTR_W    = 16,
  localparam int SEL_W   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       valid_in,
  input  logic [NUM_REQS*DATAW-1:0] data_in,
  output logic [NUM_REQS-1:0]       ready_in,
  output logic                      valid_out,
  output logic [DATAW-1:0]          data_out,
  output logic [SEL_W-1:0]          sel_out,
  input  logic                      ready_out,
  output logic [NUM_REQS*CTR_W-1:0] stall_cnt
);

  logic                valid_r;
  logic [DATAW-1:0]    data_r;
  logic [SEL_W-1:0]    sel_r;
  logic [SEL_W-1:0]    ptr;
  logic [NUM_REQS-1:0] grant;
  logic [SEL_W-1:0]    grant_idx;
  logic                can_accept;
  logic                fire;
  logic [CTR_W-1:0]    stall_q [NUM_REQS];

  assign can_accept = ~valid_r | ready_out;

  // Search upward from ptr, wrapping, and take the first requesting lane.
  always_comb begin
    int   idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQS) idx = idx - NUM_REQS;
      if (!found && valid_in[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = SEL_W'(idx);
      end
    end
  end

  assign ready_in = grant & {NUM_REQS{can_accept}};
  assign fire     = |(valid_in & ready_in);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r <= 1'b0;
      data_r  <= '0;
      sel_r   <= '0;
      ptr     <= '0;
    end else if (fire) begin
      valid_r <= 1'b1;
      data_r  <= data_in[int'(grant_idx)*DATAW +: DATAW];
      sel_r   <= grant_idx;
      ptr     <= (int'(grant_idx) == NUM_REQS-1) ? '0 : grant_idx + 1'b1;
    end else if (valid_r && ready_out) begin
      valid_r <= 1'b0;
    end
  end

  // A lane stalls whenever it requests but is not accepted; counters stick at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQS; i++) stall_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (valid_in[i] && !ready_in[i] && (stall_q[i] != {CTR_W{1'b1}}))
          stall_q[i] <= stall_q[i] + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_stall
    assign stall_cnt[i*CTR_W +: CTR_W] = stall_q[i];
  end

  assign valid_out = valid_r;
  assign data_out  = data_r;
  assign sel_out   = sel_r;

endmodule

// File: tb/tb_vx_dispatch_arb.sv
// Directed and randomized self-checking bench for vx_dispatch_arb (4 lanes, 4-bit stall counters).
module tb_vx_dispatch_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    valid_in;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]    ready_in;
  logic            valid_out;
  logic [DW-1:0]   data_out;
  logic [1:0]      sel_out;
  logic            ready_out;
  logic [N*CW-1:0] stall_cnt;

  logic [DW-1:0]   lane_data [N];
  int              tests_run = 0;
  int              tests_failed = 0;

  always #5 clk = ~clk;

  always_comb data_in = {lane_data[3], lane_data[2], lane_data[1], lane_data[0]};

  vx_dispatch_arb #(.NUM_REQS(N), .DATAW(DW), .CTR_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .sel_out   (sel_out),
    .ready_out (ready_out),
    .stall_cnt (stall_cnt)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic ro);
    @(negedge clk);
    valid_in  = v;
    ready_out = ro;
    #1;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Random-phase reference model state
  logic [N-1:0]    hold;
  logic [DW-1:0]   m_data;
  logic [1:0]      m_sel;
  logic [1:0]      m_ptr;
  logic            m_valid;
  logic [CW-1:0]   m_cnt [N];
  int              seq  [N];
  int              wait_cnt [N];

  initial begin
    reset     = 1'b0;
    valid_in  = '0;
    ready_out = 1'b1;
    for (int i = 0; i < N; i++) lane_data[i] = 32'h1000_0000 + i;
    #1;
    checkOutput("rst_valid", 64'(valid_out), 64'd0);
    checkOutput("rst_sel",   64'(sel_out),   64'd0);
    checkOutput("rst_data",  64'(data_out),  64'd0);
    checkOutput("rst_stall", 64'(stall_cnt), 64'd0);
    valid_in = 4'b1111;
    #1;
    checkOutput("rst_ready", 64'(ready_in), 64'b0001);
    valid_in = '0;
    @(negedge clk);
    reset = 1'b1;

    // Full contention rotates through every lane
    for (int c = 0; c < 8; c++) begin
      applyStimulus(4'b1111, 1'b1);
      checkOutput($sformatf("rr_ready%0d", c), 64'(ready_in), 64'(4'b0001 << (c % 4)));
      @(posedge clk); #1;
      checkOutput($sformatf("rr_out%0d", c), {29'd0, valid_out, sel_out, data_out},
                  {29'd0, 1'b1, 2'(c % 4), 32'h1000_0000 + 32'(c % 4)});
    end
    checkOutput("rr_stall", 64'(stall_cnt), 64'h6666);
    applyStimulus(4'b0000, 1'b1);
    @(posedge clk); #1;
    checkOutput("drain_out", {29'd0, valid_out, sel_out, data_out}, {29'd0, 1'b0, 2'd3, 32'h1000_0003});

    // Single lane 2, then pointer must sit at lane 3
    lane_data[2] = 32'hA5A5_A5A5;
    applyStimulus(4'b0100, 1'b1);
    checkOutput("l2_ready", 64'(ready_in), 64'b0100);
    @(posedge clk); #1;
    checkOutput("l2_out", {29'd0, valid_out, sel_out, data_out}, {29'd0, 1'b1, 2'd2, 32'hA5A5_A5A5});
    valid_in = 4'b1111;
    #1;
    checkOutput("l2_ptr", 64'(ready_in), 64'b1000);
    valid_in = 4'b0000;

    // Asynchronous reset while holding a valid payload
    checkOutput("pre_rst_stall", 64'(stall_cnt), 64'h6666);
    checkOutput("pre_rst_valid", 64'(valid_out), 64'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_valid", 64'(valid_out), 64'd0);
    checkOutput("async_sel",   64'(sel_out),   64'd0);
    checkOutput("async_data",  64'(data_out),  64'd0);
    checkOutput("async_stall", 64'(stall_cnt), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(4'b1010, 1'b1);
    checkOutput("post_rst_ready1", 64'(ready_in), 64'b0010);
    @(posedge clk); #1;
    checkOutput("post_rst_sel1", 64'(sel_out), 64'd1);
    applyStimulus(4'b1010, 1'b1);
    checkOutput("post_rst_ready3", 64'(ready_in), 64'b1000);
    @(posedge clk); #1;
    checkOutput("post_rst_sel3", 64'(sel_out), 64'd3);

    // Backpressure: first accept, then 4 blocked cycles, then resume
    valid_in = '0;
    pulseReset();
    lane_data[0] = 32'hD000_0000;
    lane_data[1] = 32'hD111_1111;
    applyStimulus(4'b0011, 1'b0);
    checkOutput("bp_first_ready", 64'(ready_in), 64'b0001);
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(4'b0011, 1'b0);
      checkOutput($sformatf("bp_ready%0d", c), 64'(ready_in), 64'd0);
      @(posedge clk); #1;
      checkOutput($sformatf("bp_out%0d", c), {29'd0, valid_out, sel_out, data_out},
                  {29'd0, 1'b1, 2'd0, 32'hD000_0000});
    end
    checkOutput("bp_stall", 64'(stall_cnt), 64'h0054);
    applyStimulus(4'b0011, 1'b1);
    checkOutput("bp_resume_ready1", 64'(ready_in), 64'b0010);
    @(posedge clk); #1;
    checkOutput("bp_resume_out1", {29'd0, valid_out, sel_out, data_out}, {29'd0, 1'b1, 2'd1, 32'hD111_1111});
    applyStimulus(4'b0011, 1'b1);
    checkOutput("bp_resume_ready0", 64'(ready_in), 64'b0001);
    @(posedge clk); #1;
    checkOutput("bp_resume_out0", {29'd0, valid_out, sel_out, data_out}, {29'd0, 1'b1, 2'd0, 32'hD000_0000});
    checkOutput("bp_resume_stall", 64'(stall_cnt), 64'h0065);

    // Saturation of lane 3 counter
    valid_in = '0;
    pulseReset();
    applyStimulus(4'b1000, 1'b0);
    checkOutput("sat_first_ready", 64'(ready_in), 64'b1000);
    @(posedge clk); #1;
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(4'b1000, 1'b0);
      @(posedge clk); #1;
      if (k == 14) checkOutput("sat_14", 64'(stall_cnt), 64'hE000);
      if (k == 15) checkOutput("sat_15", 64'(stall_cnt), 64'hF000);
    end
    checkOutput("sat_20", 64'(stall_cnt), 64'hF000);

    // Randomized traffic against a reference model
    valid_in = '0;
    pulseReset();
    hold = '0; m_data = '0; m_sel = '0; m_ptr = '0; m_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = '0; seq[i] = 0; wait_cnt[i] = 0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic [N-1:0] exp_ready;
      logic         can;
      logic         found;
      int           g;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!hold[i] && ($urandom_range(0, 1) == 1)) begin
          hold[i]      = 1'b1;
          lane_data[i] = {4'(i), 28'(seq[i])};
          seq[i]++;
          wait_cnt[i]  = 0;
        end
      end
      valid_in  = hold;
      ready_out = ($urandom_range(0, 3) != 0);
      #1;
      can = !m_valid || ready_out;
      exp_ready = '0;
      found = 1'b0;
      g = 0;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (int'(m_ptr) + k) % N;
        if (!found && hold[idx]) begin
          found = 1'b1;
          g = idx;
        end
      end
      if (found && can) exp_ready[g] = 1'b1;
      checkOutput("rnd_ready", 64'(ready_in), 64'(exp_ready));
      for (int i = 0; i < N; i++)
        if (hold[i] && !exp_ready[i] && m_cnt[i] != 4'hF) m_cnt[i] = m_cnt[i] + 1'b1;
      if (exp_ready != '0) begin
        checkOutput("rnd_starve", 64'(wait_cnt[g] <= N), 64'd1);
        for (int i = 0; i < N; i++) if (i != g && hold[i]) wait_cnt[i]++;
        m_data  = lane_data[g];
        m_sel   = 2'(g);
        m_valid = 1'b1;
        m_ptr   = 2'((g + 1) % N);
      end else if (m_valid && ready_out) begin
        m_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (exp_ready != '0) hold[g] = 1'b0;
      checkOutput("rnd_out", {29'd0, valid_out, sel_out, data_out}, {29'd0, m_valid, m_sel, m_data});
      checkOutput("rnd_stall", 64'(stall_cnt), 64'({m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]}));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
